// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if -- receive byte stream leaving uart_rx_ctrl.
//
// Handshake: the master holds m_valid high with stable m_data/m_perr until the
// slave accepts. A transfer happens on every rising clk edge where m_valid and
// m_ready are both high. m_ready may be asserted at any time, including while
// m_valid is low. That cycle transfers nothing.
interface uart_rx_ctrl_if;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_perr;
    logic       m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_perr,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_perr,
        output m_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl -- configuration sequencer and receive FIFO for a uart_rx core.
//
// Three-state controller (RECONF / RUN / FRAME):
// - It applies pending line configuration only between frames.
// - It watches for start bits and times out frames that never complete.
// - Every rising edge of rx_ready pushes {perr, rx_data} into a
//   first-word-fall-through FIFO.
//
// Optional feature macro: UART_RX_CTRL_ERRCNT_EN enables the parity-error and
// timeout counters (perr_cnt / tmo_cnt). Without it both read as constant 0
// and cnt_clr has no effect.
module uart_rx_ctrl #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int RECONF_CYC  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    // configuration write port
    input  logic                          cfg_wr,
    input  logic [31:0]                   cfg_baudrate,
    input  logic [1:0]                    cfg_stop_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_type,
    // receiver side
    input  logic                          rx_line,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_parity_valid,
    output logic                          rx_en,
    output logic [31:0]                   rx_baudrate,
    output logic [1:0]                    rx_stop_bits,
    output logic                          rx_parity_en,
    output logic                          rx_parity_type,
    // received byte stream
    uart_rx_ctrl_if.master                m_if,
    // status
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr,
    output logic                          cfg_busy,
    output logic [7:0]                    perr_cnt,
    output logic [7:0]                    tmo_cnt,
    input  logic                          cnt_clr,
    // controller state (0 RECONF, 1 RUN, 2 FRAME)
    output logic [1:0]                    dbg_state
);

    localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW  = AW + 1;
    localparam int TW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int RCW = (RECONF_CYC > 1) ? $clog2(RECONF_CYC) : 1;

    localparam logic [TW-1:0]  TM_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [RCW-1:0] RC_LAST = RCW'(RECONF_CYC - 1);
    localparam logic [LW-1:0]  DEPTH_L = LW'(FIFO_DEPTH);

    localparam logic [31:0] BAUD_DEF = 32'd115200;
    localparam logic [1:0]  STOP_DEF = 2'b01;

    typedef enum logic [1:0] {
        S_RECONF = 2'd0,
        S_RUN    = 2'd1,
        S_FRAME  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            load_cfg;
    logic            tmo_hit;
    logic [RCW-1:0]  rc_cnt;
    logic [TW-1:0]   timer;
    logic            rdy_q;
    logic            rdy_rise;

    // pending configuration, applied on the next RUN -> RECONF transition
    logic            pend_valid;
    logic [31:0]     pend_baudrate;
    logic [1:0]      pend_stop_bits;
    logic            pend_parity_en;
    logic            pend_parity_type;

    // FIFO
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            push;
    logic            push_perr;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            ovf_set;
    logic [8:0]      head;

    // A byte completes when rx_ready was low at the previous edge and is high now.
    assign rdy_rise = rx_ready & ~rdy_q;

    // Remember rx_ready so that a level held high pushes only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= rx_ready;
        end
    end

    // Next-state logic. Byte-done has priority over a start bit seen in the same cycle.
    always_comb begin
        state_nx = state;
        load_cfg = 1'b0;
        tmo_hit  = 1'b0;
        case (state)
            S_RECONF: begin
                if (rc_cnt == RC_LAST) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (rdy_rise) begin
                    state_nx = S_RUN;
                end else if (!rx_line) begin
                    state_nx = S_FRAME;
                end else if (pend_valid) begin
                    state_nx = S_RECONF;
                    load_cfg = 1'b1;
                end
            end
            S_FRAME: begin
                if (rdy_rise) begin
                    state_nx = S_RUN;
                end else if (timer == TM_LAST) begin
                    state_nx = S_RUN;
                    tmo_hit  = 1'b1;
                end
            end
            default: begin
                state_nx = S_RECONF;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RECONF;
        end else begin
            state <= state_nx;
        end
    end

    assign dbg_state = state;

    // Count the cycles spent in RECONF, starting from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst || load_cfg) begin
            rc_cnt <= '0;
        end else if (state == S_RECONF && state_nx == S_RECONF) begin
            rc_cnt <= rc_cnt + 1'b1;
        end
    end

    // Frame timer: zero on entry to FRAME, counts each cycle the frame stays open.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (state == S_FRAME && state_nx == S_FRAME) begin
            timer <= timer + 1'b1;
        end else begin
            timer <= '0;
        end
    end

    // Capture config writes at any time. A newer write replaces an unapplied one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid       <= 1'b0;
            pend_baudrate    <= BAUD_DEF;
            pend_stop_bits   <= STOP_DEF;
            pend_parity_en   <= 1'b0;
            pend_parity_type <= 1'b0;
        end else if (cfg_wr) begin
            pend_valid       <= 1'b1;
            pend_baudrate    <= cfg_baudrate;
            pend_stop_bits   <= cfg_stop_bits;
            pend_parity_en   <= cfg_parity_en;
            pend_parity_type <= cfg_parity_type;
        end else if (load_cfg) begin
            pend_valid       <= 1'b0;
        end
    end

    // Receiver configuration registers change only when RECONF is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_baudrate    <= BAUD_DEF;
            rx_stop_bits   <= STOP_DEF;
            rx_parity_en   <= 1'b0;
            rx_parity_type <= 1'b0;
        end else if (load_cfg) begin
            rx_baudrate    <= pend_baudrate;
            rx_stop_bits   <= pend_stop_bits;
            rx_parity_en   <= pend_parity_en;
            rx_parity_type <= pend_parity_type;
        end
    end

    // Registered enable and busy, both derived from where the FSM is heading.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_en    <= 1'b0;
            cfg_busy <= 1'b1;
        end else begin
            rx_en    <= (state_nx != S_RECONF);
            cfg_busy <= cfg_wr | (pend_valid & ~load_cfg) | (state_nx == S_RECONF);
        end
    end

    // FIFO control. A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
    assign push      = rdy_rise;
    assign push_perr = rx_parity_en & ~rx_parity_valid;
    assign pop       = m_if.m_valid & m_if.m_ready;
    assign full      = (count == DEPTH_L);
    assign wr_en     = push & (~full | pop);
    assign ovf_set   = push & full & ~pop;
    assign head      = mem[rd_ptr];

    // Storage array. It needs no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= {push_perr, rx_data};
        end
    end

    // Pointers and occupancy. The power-of-two depth makes the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign fifo_level  = count;
    assign m_if.m_valid = (count != '0);
    assign m_if.m_data  = m_if.m_valid ? head[7:0] : 8'h00;
    assign m_if.m_perr  = m_if.m_valid ? head[8] : 1'b0;

    // Sticky overflow flag. An overflow in the same cycle beats a clear request.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef UART_RX_CTRL_ERRCNT_EN
    logic [7:0] perr_cnt_q;
    logic [7:0] tmo_cnt_q;

    // Saturating error counters. A clear discards an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            perr_cnt_q <= 8'd0;
            tmo_cnt_q  <= 8'd0;
        end else begin
            if (push && push_perr && perr_cnt_q != 8'hFF) begin
                perr_cnt_q <= perr_cnt_q + 8'd1;
            end
            if (tmo_hit && tmo_cnt_q != 8'hFF) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end
        end
    end

    assign perr_cnt = perr_cnt_q;
    assign tmo_cnt  = tmo_cnt_q;
`else
    logic unused_cnt;

    assign perr_cnt   = 8'd0;
    assign tmo_cnt    = 8'd0;
    assign unused_cnt = ^{cnt_clr, tmo_hit};
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl -- directed bench for uart_rx_ctrl.
// Inputs change 1 ns after the rising edge. Outputs are sampled there too,
// so each sample shows the state after the edge just taken.
module tb_uart_rx_ctrl;

`ifdef UART_RX_CTRL_ERRCNT_EN
    localparam int ERRCNT = 1;
`else
    localparam int ERRCNT = 0;
`endif

    localparam logic [1:0] ST_RECONF = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FRAME  = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [31:0] cfg_baudrate;
    logic [1:0]  cfg_stop_bits;
    logic        cfg_parity_en;
    logic        cfg_parity_type;
    logic        rx_line;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        rx_parity_valid;
    logic        rx_en;
    logic [31:0] rx_baudrate;
    logic [1:0]  rx_stop_bits;
    logic        rx_parity_en;
    logic        rx_parity_type;
    logic [3:0]  fifo_level;
    logic        ovf;
    logic        ovf_clr;
    logic        cfg_busy;
    logic [7:0]  perr_cnt;
    logic [7:0]  tmo_cnt;
    logic        cnt_clr;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl_if m_if ();

    uart_rx_ctrl #(
        .FIFO_DEPTH  (8),
        .TIMEOUT_CYC (4096),
        .RECONF_CYC  (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_wr          (cfg_wr),
        .cfg_baudrate    (cfg_baudrate),
        .cfg_stop_bits   (cfg_stop_bits),
        .cfg_parity_en   (cfg_parity_en),
        .cfg_parity_type (cfg_parity_type),
        .rx_line         (rx_line),
        .rx_ready        (rx_ready),
        .rx_data         (rx_data),
        .rx_parity_valid (rx_parity_valid),
        .rx_en           (rx_en),
        .rx_baudrate     (rx_baudrate),
        .rx_stop_bits    (rx_stop_bits),
        .rx_parity_en    (rx_parity_en),
        .rx_parity_type  (rx_parity_type),
        .m_if            (m_if),
        .fifo_level      (fifo_level),
        .ovf             (ovf),
        .ovf_clr         (ovf_clr),
        .cfg_busy        (cfg_busy),
        .perr_cnt        (perr_cnt),
        .tmo_cnt         (tmo_cnt),
        .cnt_clr         (cnt_clr),
        .dbg_state       (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // global time limit
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Bounded wait for RUN; an expired budget shows up as a failed check.
    task automatic wait_run();
        int n;
        n = 0;
        while (dbg_state !== ST_RUN && n < 50) begin
            tick();
            n++;
        end
        check("wait_run", {30'd0, dbg_state}, {30'd0, ST_RUN});
    endtask

    // Start bit plus one cycle inside FRAME.
    task automatic start_frame();
        wait_run();
        rx_line = 1'b0;
        tick();
        rx_line = 1'b1;
        tick();
    endtask

    task automatic ready_rise(input logic [7:0] d, input logic pv);
        rx_data         = d;
        rx_parity_valid = pv;
        rx_ready        = 1'b1;
        tick();
    endtask

    task automatic ready_release();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] d, input logic pv);
        start_frame();
        ready_rise(d, pv);
        ready_release();
    endtask

    initial begin
        int n;
        rst = 1'b1; cfg_wr = 1'b0; cfg_baudrate = 32'd0; cfg_stop_bits = 2'd0;
        cfg_parity_en = 1'b0; cfg_parity_type = 1'b0; rx_line = 1'b1;
        rx_ready = 1'b0; rx_data = 8'h00; rx_parity_valid = 1'b0;
        ovf_clr = 1'b0; cnt_clr = 1'b0; m_if.m_ready = 1'b0;

        // reset values
        tick(); tick(); tick();
        check("rst_state", {30'd0, dbg_state}, {30'd0, ST_RECONF});
        check("rst_rx_en", {31'd0, rx_en}, 32'd0);
        check("rst_baud", rx_baudrate, 32'd115200);
        check("rst_stop", {30'd0, rx_stop_bits}, 32'd1);
        check("rst_par_en", {31'd0, rx_parity_en}, 32'd0);
        check("rst_par_type", {31'd0, rx_parity_type}, 32'd0);
        check("rst_busy", {31'd0, cfg_busy}, 32'd1);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        check("rst_m_valid", {31'd0, m_if.m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_if.m_data}, 32'd0);
        check("rst_m_perr", {31'd0, m_if.m_perr}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_perr_cnt", {24'd0, perr_cnt}, 32'd0);
        check("rst_tmo_cnt", {24'd0, tmo_cnt}, 32'd0);

        // rx_en low for two cycles after reset release, then high with cfg_busy falling
        rst = 1'b0;
        tick();
        check("rel_c1_rx_en", {31'd0, rx_en}, 32'd0);
        check("rel_c1_busy", {31'd0, cfg_busy}, 32'd1);
        tick();
        check("rel_c2_rx_en", {31'd0, rx_en}, 32'd1);
        check("rel_c2_busy", {31'd0, cfg_busy}, 32'd0);
        check("rel_c2_state", {30'd0, dbg_state}, {30'd0, ST_RUN});

        // two bytes through with the sink always ready
        m_if.m_ready = 1'b1;
        start_frame();
        check("b41_frame", {30'd0, dbg_state}, {30'd0, ST_FRAME});
        ready_rise(8'h41, 1'b1);
        check("b41_valid", {31'd0, m_if.m_valid}, 32'd1);
        check("b41_data", {24'd0, m_if.m_data}, 32'h41);
        check("b41_perr", {31'd0, m_if.m_perr}, 32'd0);
        check("b41_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
        ready_release();
        check("b41_drained", {28'd0, fifo_level}, 32'd0);
        start_frame();
        ready_rise(8'h42, 1'b1);
        check("b42_data", {24'd0, m_if.m_data}, 32'h42);
        check("b42_perr", {31'd0, m_if.m_perr}, 32'd0);
        ready_release();
        check("b42_drained", {28'd0, fifo_level}, 32'd0);

        // config write during a frame is held until the byte completes
        wait_run();
        rx_line = 1'b0;
        tick();
        rx_line = 1'b1;
        cfg_wr = 1'b1; cfg_baudrate = 32'd9600; cfg_stop_bits = 2'd2;
        cfg_parity_en = 1'b1; cfg_parity_type = 1'b1;
        tick();
        cfg_wr = 1'b0;
        check("cfgf_state", {30'd0, dbg_state}, {30'd0, ST_FRAME});
        check("cfgf_busy", {31'd0, cfg_busy}, 32'd1);
        check("cfgf_par_type", {31'd0, rx_parity_type}, 32'd0);
        check("cfgf_baud", rx_baudrate, 32'd115200);
        tick(); tick(); tick();
        check("cfgf_hold_par_en", {31'd0, rx_parity_en}, 32'd0);
        check("cfgf_hold_rx_en", {31'd0, rx_en}, 32'd1);
        ready_rise(8'h33, 1'b1);
        check("cfgd_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
        check("cfgd_par_type", {31'd0, rx_parity_type}, 32'd0);
        check("cfgd_data", {24'd0, m_if.m_data}, 32'h33);
        ready_release();
        check("cfga_state", {30'd0, dbg_state}, {30'd0, ST_RECONF});
        check("cfga_rx_en", {31'd0, rx_en}, 32'd0);
        check("cfga_par_type", {31'd0, rx_parity_type}, 32'd1);
        check("cfga_par_en", {31'd0, rx_parity_en}, 32'd1);
        check("cfga_baud", rx_baudrate, 32'd9600);
        check("cfga_stop", {30'd0, rx_stop_bits}, 32'd2);
        check("cfga_level", {28'd0, fifo_level}, 32'd0);
        tick();
        check("cfga_c2_rx_en", {31'd0, rx_en}, 32'd0);
        check("cfga_c2_busy", {31'd0, cfg_busy}, 32'd1);
        tick();
        check("cfga_c3_rx_en", {31'd0, rx_en}, 32'd1);
        check("cfga_c3_busy", {31'd0, cfg_busy}, 32'd0);

        // parity error byte; rx_ready held high pushes once
        m_if.m_ready = 1'b0;
        start_frame();
        ready_rise(8'h55, 1'b0);
        check("p55_data", {24'd0, m_if.m_data}, 32'h55);
        check("p55_perr", {31'd0, m_if.m_perr}, 32'd1);
        check("p55_perr_cnt", {24'd0, perr_cnt}, ERRCNT);
        tick(); tick();
        check("p55_hold_level", {28'd0, fifo_level}, 32'd1);
        ready_release();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("p55_cnt_clr", {24'd0, perr_cnt}, 32'd0);

        // start bit and rx_ready rise in the same cycle count as byte-done only
        wait_run();
        rx_line = 1'b0; rx_data = 8'h77; rx_parity_valid = 1'b1; rx_ready = 1'b1;
        tick();
        check("same_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
        check("same_level", {28'd0, fifo_level}, 32'd2);
        rx_line = 1'b1; rx_ready = 1'b0;
        tick();
        check("same_state2", {30'd0, dbg_state}, {30'd0, ST_RUN});
        m_if.m_ready = 1'b1;
        tick();
        check("same_head", {24'd0, m_if.m_data}, 32'h77);
        check("same_head_perr", {31'd0, m_if.m_perr}, 32'd0);
        tick();
        check("same_empty", {28'd0, fifo_level}, 32'd0);
        m_if.m_ready = 1'b0;

        // overflow: 9 bytes into 8 entries
        for (int i = 0; i < 8; i++) begin
            push_byte(i[7:0], 1'b1);
        end
        check("fill_level", {28'd0, fifo_level}, 32'd8);
        check("fill_ovf", {31'd0, ovf}, 32'd0);
        check("fill_head", {24'd0, m_if.m_data}, 32'h00);
        push_byte(8'h08, 1'b1);
        check("ovf_level", {28'd0, fifo_level}, 32'd8);
        check("ovf_set", {31'd0, ovf}, 32'd1);
        // overflow in the same cycle as ovf_clr keeps the flag
        start_frame();
        ovf_clr = 1'b1;
        ready_rise(8'h09, 1'b1);
        ovf_clr = 1'b0;
        check("ovf_clr_race", {31'd0, ovf}, 32'd1);
        ready_release();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", {31'd0, ovf}, 32'd0);
        // push and pop together while full both take effect
        start_frame();
        m_if.m_ready = 1'b1;
        ready_rise(8'h99, 1'b1);
        m_if.m_ready = 1'b0;
        check("fullpp_level", {28'd0, fifo_level}, 32'd8);
        check("fullpp_ovf", {31'd0, ovf}, 32'd0);
        check("fullpp_head", {24'd0, m_if.m_data}, 32'h01);
        ready_release();
        m_if.m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_data", {24'd0, m_if.m_data}, (i < 8) ? i : 32'h99);
            tick();
        end
        check("drain_level", {28'd0, fifo_level}, 32'd0);
        check("drain_valid", {31'd0, m_if.m_valid}, 32'd0);
        tick();
        check("pop_empty_level", {28'd0, fifo_level}, 32'd0);
        m_if.m_ready = 1'b0;

        // frame timeout
        wait_run();
        rx_line = 1'b0;
        tick();
        rx_line = 1'b1;
        n = 0;
        while (dbg_state === ST_FRAME && n < 5000) begin
            tick();
            n++;
        end
        check("tmo_cycles", n, 32'd4096);
        check("tmo_state", {30'd0, dbg_state}, {30'd0, ST_RUN});
        check("tmo_cnt", {24'd0, tmo_cnt}, ERRCNT);
        check("tmo_level", {28'd0, fifo_level}, 32'd0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("tmo_cnt_clr", {24'd0, tmo_cnt}, 32'd0);

        // reset in the middle of a frame discards FIFO contents and config
        push_byte(8'hA5, 1'b1);
        check("mid_level", {28'd0, fifo_level}, 32'd1);
        start_frame();
        rst = 1'b1;
        tick();
        check("mid_rst_level", {28'd0, fifo_level}, 32'd0);
        check("mid_rst_valid", {31'd0, m_if.m_valid}, 32'd0);
        check("mid_rst_state", {30'd0, dbg_state}, {30'd0, ST_RECONF});
        check("mid_rst_par_en", {31'd0, rx_parity_en}, 32'd0);
        rst = 1'b0;
        tick();
        check("mid_rel_c1", {31'd0, rx_en}, 32'd0);
        tick();
        check("mid_rel_c2", {31'd0, rx_en}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 4096, max clk cycles from start-bit detect to byte-done before a frame is abandoned.
REQ-003 SHALL have parameter RECONF_CYC, default 2, cycles rx_en is held low while a new configuration is applied.
REQ-004 SHALL have port clk  in  1  single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cfg_wr in 1 (config write strobe), cfg_baudrate in 32, cfg_stop_bits in 2, cfg_parity_en in 1, cfg_parity_type in 1 (0 even, 1 odd).
REQ-007 SHALL have receiver-side ports rx_line in 1 (serial line monitor), rx_ready in 1, rx_data in 8, rx_parity_valid in 1, all driven by uart_rx.
REQ-008 SHALL have receiver-config outputs rx_en out 1 (to uart_rx valid), rx_baudrate out 32, rx_stop_bits out 2, rx_parity_en out 1, rx_parity_type out 1, all registered.
REQ-009 SHALL have stream outputs m_valid out 1, m_data out 8, m_perr out 1 (parity error for m_data), input m_ready in 1.
REQ-010 SHALL have status outputs fifo_level out clog2(FIFO_DEPTH)+1, ovf out 1 (sticky), ovf_clr in 1, cfg_busy out 1, perr_cnt out 8, tmo_cnt out 8, cnt_clr in 1.

Function
REQ-011 FSM states SHALL be RECONF, RUN, FRAME.
REQ-012 RECONF: rx_en=0, rx_* config registers loaded from pending config on entry, cfg_busy=1; exits to RUN after RECONF_CYC cycles.
REQ-013 RUN: rx_en=1; rx_line sampled low (start bit) -> FRAME; else pending config present -> RECONF.
REQ-014 FRAME: rx_en=1; rx_ready rising edge -> RUN; timer reaching TIMEOUT_CYC -> RUN, tmo_cnt increment, no FIFO push.
REQ-015 Start-bit detect and rx_ready rising edge in the same cycle SHALL be treated as byte-done only.
REQ-016 cfg_wr SHALL latch cfg_* into a pending register and set cfg_busy=1 in any state; a later cfg_wr before apply overwrites pending values.
REQ-017 Configuration SHALL never change while in FRAME; pending config applies only from RUN.
REQ-018 rx_ready rising edge (low at previous edge, high at this edge) SHALL push {rx_data, perr} into FIFO at that edge; perr = rx_parity_en & ~rx_parity_valid.
REQ-019 rx_ready held high SHALL produce exactly one push.
REQ-020 FIFO SHALL be first-word-fall-through: m_valid=1 whenever fifo_level>0; pop on m_valid & m_ready.
REQ-021 Push latency: pushed byte visible on m_data/m_valid the cycle after the push edge when FIFO was empty.
REQ-022 Push to full FIFO without same-cycle pop SHALL drop the byte and set ovf; push and pop in same cycle when full SHALL both succeed, ovf unchanged.
REQ-023 Pop when empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH.
REQ-024 ovf SHALL clear on ovf_clr; a same-cycle overflow event wins (ovf stays 1).
REQ-025 perr_cnt increments on every push with perr=1; both counters saturate at 255; cnt_clr zeroes both, same-cycle increment lost.

Reset
REQ-026 rst SHALL be synchronous, active-high, highest priority over all other inputs.
REQ-027 Reset values: state RECONF, rx_en=0, rx_baudrate=115200, rx_stop_bits=2'b01, rx_parity_en=0, rx_parity_type=0, pending config cleared (defaults), cfg_busy=1.
REQ-028 Reset values: FIFO empty, fifo_level=0, m_valid=0, m_data=0, m_perr=0, ovf=0, perr_cnt=0, tmo_cnt=0, timer=0.
REQ-029 Reset mid-frame SHALL discard the frame and FIFO contents; rx_en rises RECONF_CYC cycles after rst deasserts.

Configuration
REQ-030 Macro UART_RX_CTRL_ERRCNT_EN defined: perr_cnt and tmo_cnt implemented per REQ-014/REQ-025.
REQ-031 Macro undefined: perr_cnt and tmo_cnt SHALL be constant 0, cnt_clr ignored, all other behaviour identical.

Verification
REQ-032 Reset, idle line -> rx_en=0 for 2 cycles then 1; rx_stop_bits=01, rx_baudrate=115200, cfg_busy falls with rx_en rise.
REQ-033 Feed bytes 0x41, 0x42 with valid parity, m_ready=1 -> m_data 0x41 then 0x42, m_perr=0, fifo_level returns to 0.
REQ-034 cfg_wr (parity_en=1, odd) while in FRAME -> rx_* unchanged until byte done, then rx_en low 2 cycles, rx_parity_type=1.
REQ-035 m_ready=0, 9 bytes 0x00..0x08 -> fifo_level=8, ovf=1, drained data 0x00..0x07; ovf_clr -> ovf=0.
REQ-036 Start bit with no rx_ready for 4096 cycles -> state RUN, tmo_cnt=1, fifo_level=0 (with UART_RX_CTRL_ERRCNT_EN; 0 without).
REQ-037 parity_en=1, rx_parity_valid=0 on byte 0x55 -> m_data=0x55, m_perr=1, perr_cnt=1; cnt_clr -> 0.
